wb_cmd_initiator: RTL
=====================

WB_CMD_INITIATOR -- requirements
Module: wb_cmd_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles allowed in BUS before abort (8-bit counter, valid 1..255).
REQ-002 SHALL have port wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port wb_rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid_i  in  1  command request.
REQ-005 SHALL have port cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-006 SHALL have ports cmd_we_i in 1, cmd_sel_i in 4, cmd_adr_i in 32, cmd_dat_i in 32: write enable, byte lanes, address, write data.
REQ-007 SHALL have port rsp_valid_o  out  1  response available.
REQ-008 SHALL have port rsp_ready_i  in  1  response consumed.
REQ-009 SHALL have ports rsp_dat_o out 32 (read data) and rsp_err_o out 1 (bus error or timeout).
REQ-010 SHALL have Wishbone master ports wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o, wbm_dat_o out 32; wbm_ack_i, wbm_err_i in 1; wbm_dat_i in 32.

Function
REQ-011 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE, one outstanding transaction.
REQ-012 SHALL drive cmd_ready_o = 1 only in IDLE; handshake = cmd_valid_i & cmd_ready_o at a rising edge.
REQ-013 SHALL on handshake register we/sel/adr/dat to wbm_* and enter BUS; wbm_cyc_o = wbm_stb_o = 1 from the next cycle.
REQ-014 SHALL hold all wbm_* outputs stable while in BUS (classic single cycle, no pipelining).
REQ-015 SHALL on wbm_ack_i = 1 in BUS: deassert cyc/stb next cycle, capture wbm_dat_i into rsp_dat_o for reads (0 for writes), rsp_err_o = 0, enter RESP.
REQ-016 SHALL on wbm_err_i = 1 in BUS terminate as REQ-015 but with rsp_dat_o = 0, rsp_err_o = 1.
REQ-017 SHALL give wbm_err_i priority over wbm_ack_i when both are high in the same cycle.
REQ-018 SHALL assert rsp_valid_o exactly in RESP and hold rsp_dat_o/rsp_err_o stable until rsp_ready_i = 1; then return to IDLE.
REQ-019 SHALL achieve minimum latency: handshake edge N, stb high cycle N+1, zero-wait ack at edge N+2 -> rsp_valid_o high after edge N+2.
REQ-020 SHALL accept a new command no earlier than the cycle after response consumption (cmd_ready_o low in RESP).
REQ-021 SHALL drive wbm_dat_o = 0 and wbm_sel_o = cmd_sel_i for reads; wbm_sel_o = 0 in IDLE.
REQ-022 SHALL ignore wbm_ack_i/wbm_err_i outside BUS.

Reset
REQ-023 SHALL on wb_rst_ni = 0 immediately (asynchronously) force IDLE, all wbm_* outputs 0, cmd_ready_o 0, rsp_valid_o 0, rsp_dat_o 0, rsp_err_o 0, timeout counter 0.
REQ-024 SHALL drive cmd_ready_o = 1 from the first edge after wb_rst_ni rises.
REQ-025 SHALL abort an in-flight transaction on reset with no response generated.

Configuration
REQ-026 SHALL with macro WB_CMD_INITIATOR_TIMEOUT_EN defined count BUS cycles from 1; if the count reaches TIMEOUT with no ack/err, terminate as REQ-016 (rsp_err_o = 1, rsp_dat_o = 0); counter clears on entering BUS.
REQ-027 SHALL with WB_CMD_INITIATOR_TIMEOUT_EN undefined contain no counter and wait in BUS indefinitely; TIMEOUT unused.
REQ-028 SHALL give ack/err priority over timeout in the expiry cycle.

Verification
REQ-029 Write adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, zero-wait ack -> wbm_we_o=1 for 1 cycle, rsp_valid_o after 2 edges, rsp_dat_o=0, rsp_err_o=0.
REQ-030 Read adr=0x3000_0010, slave acks after 3 wait states with 0x1234_5678 -> stb high 4 cycles, rsp_dat_o=0x1234_5678, rsp_err_o=0.
REQ-031 Read with wbm_ack_i and wbm_err_i high same cycle -> rsp_err_o=1, rsp_dat_o=0.
REQ-032 TIMEOUT=8, macro defined, slave silent -> cyc/stb drop after 8 BUS cycles, rsp_err_o=1; macro undefined -> stb held 100+ cycles, no response.
REQ-033 rsp_ready_i held 0 for 5 cycles, cmd_valid_i=1 throughout -> rsp_valid_o/rsp_dat_o stable, cmd_ready_o=0, no new bus cycle until response consumed.
REQ-034 wb_rst_ni pulled low mid-BUS -> cyc/stb 0 same cycle without an edge, rsp_valid_o=0; after release, cmd_ready_o=1 next edge.

Source files
------------

// File: rtl/wb_cmd_initiator.sv
// Command-to-Wishbone classic single-transfer initiator with one outstanding transaction.
// Optional bus timeout is enabled by defining WB_CMD_INITIATOR_TIMEOUT_EN.
module wb_cmd_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_cmd_rdy;
    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;

    logic w_cmd_fire;
    logic w_in_bus;
    logic w_ack;
    logic w_err;
    logic w_tmo;
    logic w_done;

    assign w_cmd_fire = cmd_valid_i & r_cmd_rdy;
    assign w_in_bus   = (r_state == S_BUS);
    // Error wins over a simultaneous ack; both are ignored outside BUS.
    assign w_err      = w_in_bus & wbm_err_i;
    assign w_ack      = w_in_bus & wbm_ack_i & ~wbm_err_i;

`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // r_tmo_cnt holds completed BUS cycles, so the current cycle number is r_tmo_cnt+1.
    logic [7:0] r_tmo_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_tmo_cnt <= 8'd0;
        end else if (w_cmd_fire) begin
            r_tmo_cnt <= 8'd0;
        end else if (w_in_bus) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    assign w_tmo = w_in_bus & ~wbm_ack_i & ~wbm_err_i & (r_tmo_cnt == TMO_LAST);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT != 0);
    assign w_tmo        = 1'b0;
`endif

    assign w_done = w_ack | w_err | w_tmo;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_fire)  w_state_nxt = S_BUS;
            S_BUS:   if (w_done)      w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= S_IDLE;
            r_cmd_rdy <= 1'b0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 4'd0;
            r_adr     <= 32'd0;
            r_dat     <= 32'd0;
            r_rsp_dat <= 32'd0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // Registered ready keeps it low during reset and raises it on the first edge after.
            r_cmd_rdy <= (w_state_nxt == S_IDLE);
            if (w_cmd_fire) begin
                r_cyc <= 1'b1;
                r_stb <= 1'b1;
                r_we  <= cmd_we_i;
                r_sel <= cmd_sel_i;
                r_adr <= cmd_adr_i;
                r_dat <= cmd_we_i ? cmd_dat_i : 32'd0;
            end else if (w_done) begin
                r_cyc     <= 1'b0;
                r_stb     <= 1'b0;
                r_we      <= 1'b0;
                r_sel     <= 4'd0;
                r_adr     <= 32'd0;
                r_dat     <= 32'd0;
                r_rsp_dat <= (w_ack && !r_we) ? wbm_dat_i : 32'd0;
                r_rsp_err <= ~w_ack;
            end
        end
    end

    assign cmd_ready_o = r_cmd_rdy;
    assign rsp_valid_o = (r_state == S_RESP);
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_stb;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;

endmodule
